// File: rtl/ni_tdm_out_scheduler.sv
// TDM injection scheduler of an NI endpoint (NoC clock domain). Walks the slot table,
// pops the out queue in owned slots and emits data/checkpoint flits on both links.
module ni_tdm_out_scheduler #(
   parameter  int FLIT_WIDTH = 32,
   parameter  int CT_LINKS   = 2,
   parameter  int LUT_SIZE   = 8,
   parameter  int MAX_LEN    = 8,
   localparam int SLOT_WIDTH = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1,
   localparam int CNT_WIDTH  = 16
) (
   input  logic                           clk_noc,
   input  logic                           rst_noc_n,
   input  logic                           enable,
   input  logic                           cfg_we,
   input  logic [SLOT_WIDTH-1:0]          cfg_addr,
   input  logic [CT_LINKS-1:0]            cfg_links,
   input  logic [FLIT_WIDTH-1:0]          in_flit,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [CT_LINKS*FLIT_WIDTH-1:0] out_flit,
   output logic [CT_LINKS-1:0]            out_valid,
   output logic [CT_LINKS-1:0]            out_checkpoint,
   output logic [SLOT_WIDTH-1:0]          cur_slot,
   output logic [CNT_WIDTH-1:0]           flit_cnt
);

   localparam int BURST_W = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {
      EMIT_NONE,
      EMIT_DATA,
      EMIT_CKPT
   } emit_e;

   if (CT_LINKS != 2) begin : g_bad_links
      $fatal(1, "ni_tdm_out_scheduler supports CT_LINKS == 2 only");
   end

   logic [CT_LINKS-1:0]   lut [LUT_SIZE];
   logic [CT_LINKS-1:0]   slot_links;
   logic                  ckpt_pend;
   logic [BURST_W-1:0]    burst;
   emit_e                 emit;
   logic [FLIT_WIDTH-1:0] emit_flit;
   logic [31:0]           cfg_addr_ext;

   assign cfg_addr_ext = 32'(cfg_addr);

   // Out queue handshake: in_valid says in_flit is the queue head (first-word
   // fall-through); the head is popped in every cycle where in_valid && in_ready.
   // in_ready only depends on in_valid, enable and registered state.
   always_comb begin
      slot_links = lut[cur_slot];
      emit       = EMIT_NONE;
      in_ready   = 1'b0;
      emit_flit  = '0;
      if (enable && (slot_links != '0)) begin
         if (ckpt_pend) begin
            emit = EMIT_CKPT;
         end else if (in_valid) begin
            emit     = EMIT_DATA;
            in_ready = 1'b1;
         end else if (burst != '0) begin
            emit = EMIT_CKPT;
         end
      end
      // Checkpoint payload is the count of data flits sent before it.
      if (emit == EMIT_DATA) emit_flit = in_flit;
      else                   emit_flit[CNT_WIDTH-1:0] = flit_cnt;
   end

   always_ff @(posedge clk_noc or negedge rst_noc_n) begin
      if (!rst_noc_n) begin
         for (int i = 0; i < LUT_SIZE; i++) lut[i] <= '0;
      end else if (cfg_we && (cfg_addr_ext < 32'(LUT_SIZE))) begin
         lut[cfg_addr] <= cfg_links;
      end
   end

   always_ff @(posedge clk_noc or negedge rst_noc_n) begin
      if (!rst_noc_n) begin
         cur_slot <= '0;
      end else if (!enable || (cur_slot == SLOT_WIDTH'(LUT_SIZE - 1))) begin
         cur_slot <= '0;
      end else begin
         cur_slot <= cur_slot + SLOT_WIDTH'(1);
      end
   end

   // A disabled scheduler restarts with a checkpoint so the receiver resyncs.
   always_ff @(posedge clk_noc or negedge rst_noc_n) begin
      if (!rst_noc_n) begin
         ckpt_pend <= 1'b1;
         burst     <= '0;
         flit_cnt  <= '0;
      end else if (!enable) begin
         ckpt_pend <= 1'b1;
         burst     <= '0;
      end else begin
         case (emit)
            EMIT_CKPT: begin
               ckpt_pend <= 1'b0;
               burst     <= '0;
            end
            EMIT_DATA: begin
               flit_cnt <= flit_cnt + CNT_WIDTH'(1);
               burst    <= burst + BURST_W'(1);
               if (burst == BURST_W'(MAX_LEN - 1)) ckpt_pend <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_noc or negedge rst_noc_n) begin
      if (!rst_noc_n) begin
         out_valid      <= '0;
         out_checkpoint <= '0;
         out_flit       <= '0;
      end else begin
         for (int i = 0; i < CT_LINKS; i++) begin
            out_valid[i]      <= (emit != EMIT_NONE) && slot_links[i];
            out_checkpoint[i] <= (emit == EMIT_CKPT) && slot_links[i];
            if ((emit != EMIT_NONE) && slot_links[i])
               out_flit[i*FLIT_WIDTH +: FLIT_WIDTH] <= emit_flit;
         end
      end
   end

endmodule

// File: tb/tb_ni_tdm_out_scheduler.sv
// Bench for ni_tdm_out_scheduler: per-cycle reference model scoreboard plus
// scenario-level checks of the emitted data/checkpoint flit sequences.
module tb_ni_tdm_out_scheduler;

   localparam int FW    = 32;
   localparam int NL    = 2;
   localparam int LUT   = 8;
   localparam int MAXL  = 8;
   localparam int SW    = 3;
   localparam int CW    = 16;
   localparam int REC_W = 1 + 2*NL + NL*FW + SW + CW;
   localparam int EV_W  = 1 + NL + FW;
   localparam int K_NONE = 0;
   localparam int K_DATA = 1;
   localparam int K_CKPT = 2;

   logic              clk_noc = 1'b0;
   logic              rst_noc_n;
   logic              enable;
   logic              cfg_we;
   logic [SW-1:0]     cfg_addr;
   logic [NL-1:0]     cfg_links;
   logic [FW-1:0]     in_flit;
   logic              in_valid;
   logic              in_ready;
   logic [NL*FW-1:0]  out_flit;
   logic [NL-1:0]     out_valid;
   logic [NL-1:0]     out_checkpoint;
   logic [SW-1:0]     cur_slot;
   logic [CW-1:0]     flit_cnt;

   ni_tdm_out_scheduler #(
      .FLIT_WIDTH (FW),
      .CT_LINKS   (NL),
      .LUT_SIZE   (LUT),
      .MAX_LEN    (MAXL)
   ) dut (
      .clk_noc        (clk_noc),
      .rst_noc_n      (rst_noc_n),
      .enable         (enable),
      .cfg_we         (cfg_we),
      .cfg_addr       (cfg_addr),
      .cfg_links      (cfg_links),
      .in_flit        (in_flit),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_flit       (out_flit),
      .out_valid      (out_valid),
      .out_checkpoint (out_checkpoint),
      .cur_slot       (cur_slot),
      .flit_cnt       (flit_cnt)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_noc = ~clk_noc;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int nvec = 0;
   int nerr = 0;
   logic [REC_W-1:0] exp_q[$];
   logic [REC_W-1:0] obs_q[$];
   logic [EV_W-1:0]  ev_q[$];
   logic [EV_W-1:0]  ev_exp[$];
   logic [FW-1:0]    src_q[$];

   // ---------------- reference model ----------------
   logic [NL-1:0] m_lut [LUT];
   int            m_slot;
   int            m_burst;
   bit            m_pend;
   logic [CW-1:0] m_cnt;
   logic [FW-1:0] m_flit [NL];
   logic [NL-1:0] m_ov;
   logic [NL-1:0] m_ock;

   task automatic model_reset();
      for (int i = 0; i < LUT; i++) m_lut[i] = '0;
      for (int i = 0; i < NL; i++) m_flit[i] = '0;
      m_slot = 0; m_burst = 0; m_pend = 1'b1; m_cnt = '0; m_ov = '0; m_ock = '0;
   endtask

   // ---------------- driver ----------------
   // One clock: present queue head, advance the model by the slot rules,
   // record expected and observed cycle records. Starts and ends after negedge.
   task automatic step();
      logic          rdy;
      logic [NL-1:0] links_now;
      int            kind;
      in_valid = (src_q.size() != 0);
      in_flit  = '0;
      if (src_q.size() != 0) in_flit = src_q[0];
      #1;
      rdy       = in_ready;
      links_now = m_lut[m_slot];
      kind      = K_NONE;
      if (enable && links_now != '0) begin
         if (m_pend)              kind = K_CKPT;
         else if (in_valid)       kind = K_DATA;
         else if (m_burst != 0)   kind = K_CKPT;
      end
      @(posedge clk_noc);
      m_ov = '0; m_ock = '0;
      if (kind != K_NONE) begin
         for (int i = 0; i < NL; i++)
            if (links_now[i]) m_flit[i] = (kind == K_DATA) ? in_flit : FW'(m_cnt);
         m_ov  = links_now;
         m_ock = (kind == K_CKPT) ? links_now : '0;
      end
      if (!enable) begin
         m_slot = 0; m_pend = 1'b1; m_burst = 0;
      end else begin
         m_slot = (m_slot + 1) % LUT;
         if (kind == K_CKPT) begin
            m_pend = 1'b0; m_burst = 0;
         end else if (kind == K_DATA) begin
            m_cnt = m_cnt + 16'd1;
            m_burst++;
            if (m_burst == MAXL) m_pend = 1'b1;
            void'(src_q.pop_front());
         end
      end
      if (cfg_we && int'(cfg_addr) < LUT) m_lut[cfg_addr] = cfg_links;
      #1;
      exp_q.push_back({(kind == K_DATA), m_ov, m_ock, m_flit[1], m_flit[0], SW'(m_slot), m_cnt});
      obs_q.push_back({rdy, out_valid, out_checkpoint, out_flit, cur_slot, flit_cnt});
      if (out_valid != '0)
         ev_q.push_back({|out_checkpoint, out_valid, out_valid[0] ? out_flit[FW-1:0] : out_flit[2*FW-1:FW]});
      cfg_we = 1'b0;
      @(negedge clk_noc);
   endtask

   task automatic apply_reset();
      rst_noc_n = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_links = '0;
      in_valid = 1'b0; in_flit = '0;
      src_q.delete(); ev_q.delete(); ev_exp.delete();
      model_reset();
      @(negedge clk_noc);
      @(negedge clk_noc);
      rst_noc_n = 1'b1;
   endtask

   task automatic write_lut(input int addr, input logic [NL-1:0] links);
      cfg_we = 1'b1; cfg_addr = SW'(addr); cfg_links = links;
      step();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [REC_W-1:0] e, o;
      rst_noc_n = 1'b0; enable = 1'b1; in_valid = 1'b1; in_flit = $urandom;
      cfg_we = 1'b1; cfg_addr = 3'd2; cfg_links = 2'b11;
      @(negedge clk_noc);
      @(negedge clk_noc);
      #1;
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
      nvec++; if (out_valid !== 2'b00) begin nerr++; $display("FAIL reset out_valid: got %b want 00", out_valid); end
      nvec++; if (out_checkpoint !== 2'b00) begin nerr++; $display("FAIL reset out_checkpoint: got %b want 00", out_checkpoint); end
      nvec++; if (out_flit !== 64'h0) begin nerr++; $display("FAIL reset out_flit: got %h want 0", out_flit); end
      nvec++; if (cur_slot !== 3'd0) begin nerr++; $display("FAIL reset cur_slot: got %0d want 0", cur_slot); end
      nvec++; if (flit_cnt !== 16'd0) begin nerr++; $display("FAIL reset flit_cnt: got %h want 0", flit_cnt); end
      apply_reset();
      // writes presented during reset must not stick: a full period stays silent
      src_q.push_back($urandom);
      enable = 1'b1;
      repeat (LUT) step();
      nvec++; if (ev_q.size() != 0) begin nerr++; $display("FAIL reset table_empty: got %0d emits want 0", ev_q.size()); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nvec++;
         if (o !== e) begin nerr++; $display("FAIL reset cycle: got %h want %h", o, e); end
      end
   endtask

   task automatic test_basic();
      logic [REC_W-1:0] e, o;
      logic [FW-1:0] a, b;
      apply_reset();
      write_lut(2, 2'b11);
      a = $urandom; b = $urandom;
      src_q.push_back(a); src_q.push_back(b);
      enable = 1'b1;
      repeat (4*LUT) step();
      ev_exp.push_back({1'b1, 2'b11, 32'd0});
      ev_exp.push_back({1'b0, 2'b11, a});
      ev_exp.push_back({1'b0, 2'b11, b});
      ev_exp.push_back({1'b1, 2'b11, 32'd2});
      nvec++; if (ev_q.size() != ev_exp.size()) begin nerr++; $display("FAIL basic events: got %0d want %0d", ev_q.size(), ev_exp.size()); end
      foreach (ev_exp[i]) if (i < ev_q.size()) begin
         nvec++; if (ev_q[i] !== ev_exp[i]) begin nerr++; $display("FAIL basic event %0d: got %h want %h", i, ev_q[i], ev_exp[i]); end
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nvec++;
         if (o !== e) begin nerr++; $display("FAIL basic cycle: got %h want %h", o, e); end
      end
   endtask

   task automatic test_max_len();
      logic [REC_W-1:0] e, o;
      logic [FW-1:0] d;
      apply_reset();
      for (int s = 0; s < LUT; s++) write_lut(s, 2'b11);
      for (int i = 0; i < 20; i++) begin
         d = $urandom;
         src_q.push_back(d);
         if (i % MAXL == 0) ev_exp.push_back({1'b1, 2'b11, FW'(i)});
         ev_exp.push_back({1'b0, 2'b11, d});
      end
      ev_exp.push_back({1'b1, 2'b11, 32'd20});
      enable = 1'b1;
      repeat (30) step();
      nvec++; if (ev_q.size() != ev_exp.size()) begin nerr++; $display("FAIL max_len events: got %0d want %0d", ev_q.size(), ev_exp.size()); end
      foreach (ev_exp[i]) if (i < ev_q.size()) begin
         nvec++; if (ev_q[i] !== ev_exp[i]) begin nerr++; $display("FAIL max_len event %0d: got %h want %h", i, ev_q[i], ev_exp[i]); end
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nvec++;
         if (o !== e) begin nerr++; $display("FAIL max_len cycle: got %h want %h", o, e); end
      end
   endtask

   task automatic test_single_link();
      logic [REC_W-1:0] e, o;
      logic [FW-1:0] d;
      apply_reset();
      write_lut(1, 2'b01);
      ev_exp.push_back({1'b1, 2'b01, 32'd0});
      for (int i = 0; i < 5; i++) begin
         d = $urandom; src_q.push_back(d); ev_exp.push_back({1'b0, 2'b01, d});
      end
      ev_exp.push_back({1'b1, 2'b01, 32'd5});
      enable = 1'b1;
      repeat (7*LUT) step();
      nvec++; if (flit_cnt !== 16'd5) begin nerr++; $display("FAIL single_link flit_cnt: got %0d want 5", flit_cnt); end
      nvec++; if (ev_q.size() != ev_exp.size()) begin nerr++; $display("FAIL single_link events: got %0d want %0d", ev_q.size(), ev_exp.size()); end
      foreach (ev_exp[i]) if (i < ev_q.size()) begin
         nvec++; if (ev_q[i] !== ev_exp[i]) begin nerr++; $display("FAIL single_link event %0d: got %h want %h", i, ev_q[i], ev_exp[i]); end
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nvec++;
         if (o !== e) begin nerr++; $display("FAIL single_link cycle: got %h want %h", o, e); end
      end
   endtask

   task automatic test_cfg_same_cycle();
      logic [REC_W-1:0] e, o;
      logic [FW-1:0] f0, f1;
      apply_reset();
      f0 = $urandom; f1 = $urandom;
      src_q.push_back(f0); src_q.push_back(f1);
      enable = 1'b1;
      repeat (3) step();
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_links = 2'b11;
      step();
      repeat (4) step();
      nvec++; if (ev_q.size() != 0) begin nerr++; $display("FAIL cfg_same_cycle first_period: got %0d emits want 0", ev_q.size()); end
      repeat (32) step();
      ev_exp.push_back({1'b1, 2'b11, 32'd0});
      ev_exp.push_back({1'b0, 2'b11, f0});
      ev_exp.push_back({1'b0, 2'b11, f1});
      ev_exp.push_back({1'b1, 2'b11, 32'd2});
      nvec++; if (ev_q.size() != ev_exp.size()) begin nerr++; $display("FAIL cfg_same_cycle events: got %0d want %0d", ev_q.size(), ev_exp.size()); end
      foreach (ev_exp[i]) if (i < ev_q.size()) begin
         nvec++; if (ev_q[i] !== ev_exp[i]) begin nerr++; $display("FAIL cfg_same_cycle event %0d: got %h want %h", i, ev_q[i], ev_exp[i]); end
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nvec++;
         if (o !== e) begin nerr++; $display("FAIL cfg_same_cycle cycle: got %h want %h", o, e); end
      end
   endtask

   task automatic test_enable_drop();
      logic [REC_W-1:0] e, o;
      int idx;
      apply_reset();
      write_lut(0, 2'b11);
      write_lut(4, 2'b10);
      for (int i = 0; i < 10; i++) src_q.push_back($urandom);
      enable = 1'b1;
      repeat (21) step();                       // ckpt0 then five data flits
      enable = 1'b0;
      step();
      nvec++; if (cur_slot !== 3'd0) begin nerr++; $display("FAIL enable_drop cur_slot: got %0d want 0", cur_slot); end
      repeat (2) step();
      nvec++; if (flit_cnt !== 16'd5) begin nerr++; $display("FAIL enable_drop held_cnt: got %0d want 5", flit_cnt); end
      idx = ev_q.size();
      enable = 1'b1;
      step();
      nvec++;
      if (ev_q.size() != idx + 1) begin nerr++; $display("FAIL enable_drop resume_emit: got %0d emits want 1", ev_q.size() - idx); end
      else if (ev_q[idx] !== {1'b1, 2'b11, 32'd5}) begin nerr++; $display("FAIL enable_drop resume_ckpt: got %h want %h", ev_q[idx], {1'b1, 2'b11, 32'd5}); end
      repeat (8) step();                        // two more data flits: burst in progress
      rst_noc_n = 1'b0;
      #2;
      nvec++; if (out_valid !== 2'b00) begin nerr++; $display("FAIL mid_reset out_valid: got %b want 00", out_valid); end
      nvec++; if (out_checkpoint !== 2'b00) begin nerr++; $display("FAIL mid_reset out_checkpoint: got %b want 00", out_checkpoint); end
      nvec++; if (flit_cnt !== 16'd0) begin nerr++; $display("FAIL mid_reset flit_cnt: got %0d want 0", flit_cnt); end
      nvec++; if (cur_slot !== 3'd0) begin nerr++; $display("FAIL mid_reset cur_slot: got %0d want 0", cur_slot); end
      nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL mid_reset in_ready: got %b want 0", in_ready); end
      model_reset();
      @(negedge clk_noc);
      rst_noc_n = 1'b1;
      enable = 1'b0;
      write_lut(0, 2'b11);
      enable = 1'b1;
      idx = ev_q.size();
      step();
      nvec++;
      if (ev_q.size() != idx + 1) begin nerr++; $display("FAIL mid_reset resume_emit: got %0d emits want 1", ev_q.size() - idx); end
      else if (ev_q[idx] !== {1'b1, 2'b11, 32'd0}) begin nerr++; $display("FAIL mid_reset resume_ckpt: got %h want %h", ev_q[idx], {1'b1, 2'b11, 32'd0}); end
      repeat (10) step();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nvec++;
         if (o !== e) begin nerr++; $display("FAIL enable_drop cycle: got %h want %h", o, e); end
      end
   endtask

   task automatic test_random();
      logic [REC_W-1:0] e, o;
      apply_reset();
      for (int k = 0; k < 600; k++) begin
         enable = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 3) == 0) begin
            cfg_we = 1'b1; cfg_addr = SW'($urandom_range(0, LUT-1)); cfg_links = NL'($urandom_range(0, 3));
         end
         if (src_q.size() < 12 && $urandom_range(0, 1) == 1) src_q.push_back($urandom);
         step();
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nvec++;
         if (o !== e) begin nerr++; $display("FAIL random cycle: got %h want %h", o, e); end
      end
   endtask

   task automatic test_wrap();
      logic [REC_W-1:0] e, o;
      logic [FW-1:0] d;
      apply_reset();
      for (int s = 0; s < LUT; s++) write_lut(s, 2'b11);
      for (int i = 0; i < 65534; i++) src_q.push_back($urandom);
      enable = 1'b1;
      for (int k = 0; k < 80000 && src_q.size() != 0; k++) step();
      nvec++; if (flit_cnt !== 16'hFFFE) begin nerr++; $display("FAIL wrap preload: got %h want fffe", flit_cnt); end
      ev_q.delete();
      step();                                   // queue empty, burst 6 -> flush
      ev_exp.push_back({1'b1, 2'b11, 32'h0000_FFFE});
      for (int i = 0; i < 3; i++) begin
         d = $urandom; src_q.push_back(d); ev_exp.push_back({1'b0, 2'b11, d});
      end
      ev_exp.push_back({1'b1, 2'b11, 32'h0000_0001});
      step();
      nvec++; if (flit_cnt !== 16'hFFFF) begin nerr++; $display("FAIL wrap cnt1: got %h want ffff", flit_cnt); end
      step();
      nvec++; if (flit_cnt !== 16'h0000) begin nerr++; $display("FAIL wrap cnt2: got %h want 0000", flit_cnt); end
      step();
      nvec++; if (flit_cnt !== 16'h0001) begin nerr++; $display("FAIL wrap cnt3: got %h want 0001", flit_cnt); end
      repeat (2) step();
      nvec++; if (ev_q.size() != ev_exp.size()) begin nerr++; $display("FAIL wrap events: got %0d want %0d", ev_q.size(), ev_exp.size()); end
      foreach (ev_exp[i]) if (i < ev_q.size()) begin
         nvec++; if (ev_q[i] !== ev_exp[i]) begin nerr++; $display("FAIL wrap event %0d: got %h want %h", i, ev_q[i], ev_exp[i]); end
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); nvec++;
         if (o !== e) begin nerr++; $display("FAIL wrap cycle: got %h want %h", o, e); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_max_len();
      test_single_link();
      test_cfg_same_cycle();
      test_enable_drop();
      test_random();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
